// File: rtl/ddr3_tester_pkg.sv
// Shared encodings for the DDR3 local-interface memory tester.
package ddr3_tester_pkg;

  typedef enum logic [3:0] {
    CMD_NOP   = 4'b0000,
    CMD_READ  = 4'b0001,
    CMD_WRITE = 4'b0010
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CMD,
    S_WR_DATA,
    S_RD_CMD,
    S_RD_WAIT,
    S_DONE
  } state_e;

  localparam int BEATS_PER_CMD = 2;
  localparam int ADDR_STEP     = 8;

endpackage

// File: rtl/ddr3_pattern_gen.sv
// Beat index to test word: w = idx ^ SEED, beat = {~w, w}.
module ddr3_pattern_gen #(
  parameter int          DATA_W = 64,
  parameter logic [31:0] SEED   = 32'h5A5A_1234
) (
  input  logic [31:0]       beat_idx,
  output logic [DATA_W-1:0] beat
);

  logic [31:0] w;

  assign w    = beat_idx ^ SEED;
  assign beat = DATA_W'({~w, w});

endmodule

// File: rtl/ddr3_mem_tester.sv
// Write-then-readback self test driving a DDR3 controller local interface.
module ddr3_mem_tester
  import ddr3_tester_pkg::*;
#(
  parameter int          ADDR_W    = 26,
  parameter int          DATA_W    = 64,
  parameter int          NUM_CMDS  = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [31:0] SEED      = 32'h5A5A_1234,
  parameter int          TIMEOUT   = 4096
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                init_done,
  output logic [3:0]          cmd,
  output logic                cmd_valid,
  input  logic                cmd_rdy,
  output logic [ADDR_W-1:0]   addr,
  output logic [4:0]          cmd_burst_cnt,
  output logic                ofly_burst_len,
  output logic [DATA_W-1:0]   write_data,
  output logic [DATA_W/8-1:0] data_mask,
  input  logic                datain_rdy,
  input  logic [DATA_W-1:0]   read_data,
  input  logic                read_data_valid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);
  localparam logic [15:0]       LAST_CMD = 16'(NUM_CMDS - 1);
  localparam logic [16:0]       TOTAL    = 17'(BEATS_PER_CMD * NUM_CMDS);
  localparam logic [31:0]       WD_LAST  = 32'(TIMEOUT - 1);

  state_e              state, state_nxt;
  logic [15:0]         cmd_idx;
  logic                wr_beat;
  logic [16:0]         rx_cnt;
  logic [31:0]         wdog;
  logic                active, rd_phase, cmd_acc, rx_take, activity, wd_fire, go;
  logic [DATA_W-1:0]   wr_pat, rd_pat;

  assign cmd_burst_cnt  = 5'b00001;
  assign ofly_burst_len = 1'b0;
  assign data_mask      = '0;

  assign go       = (state == S_IDLE) && start && init_done;
  assign active   = (state == S_WR_CMD) || (state == S_WR_DATA) ||
                    (state == S_RD_CMD) || (state == S_RD_WAIT);
  assign rd_phase = (state == S_RD_CMD) || (state == S_RD_WAIT);
  assign cmd_acc  = cmd_valid && cmd_rdy;
  assign rx_take  = rd_phase && read_data_valid && (rx_cnt != TOTAL);
  assign activity = cmd_acc || datain_rdy || read_data_valid;
  assign wd_fire  = active && !activity && (wdog == WD_LAST);

  ddr3_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_pat (
    .beat_idx ({15'd0, cmd_idx, wr_beat}),
    .beat     (wr_pat)
  );

  ddr3_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_rd_pat (
    .beat_idx ({15'd0, rx_cnt}),
    .beat     (rd_pat)
  );

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start && init_done) state_nxt = S_WR_CMD;
      S_WR_CMD:  if (cmd_acc) state_nxt = S_WR_DATA;
      S_WR_DATA: if (datain_rdy && wr_beat)
                   state_nxt = (cmd_idx == LAST_CMD) ? S_RD_CMD : S_WR_CMD;
      S_RD_CMD:  if (cmd_acc && (cmd_idx == LAST_CMD)) state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (rx_cnt == TOTAL) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    // Watchdog abort overrides whatever phase is stuck.
    if (wd_fire) state_nxt = S_DONE;
  end

  always_comb begin
    cmd       = CMD_NOP;
    cmd_valid = 1'b0;
    addr      = '0;
    if ((state == S_WR_CMD) || (state == S_RD_CMD)) begin
      cmd_valid = 1'b1;
      cmd       = (state == S_WR_CMD) ? CMD_WRITE : CMD_READ;
      addr      = BASE + ADDR_W'(cmd_idx) * STEP;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_idx        <= '0;
      wr_beat        <= 1'b0;
      rx_cnt         <= '0;
      wdog           <= '0;
      write_data     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (go) begin
        cmd_idx        <= '0;
        wr_beat        <= 1'b0;
        rx_cnt         <= '0;
        busy           <= 1'b1;
        done           <= 1'b0;
        pass           <= 1'b0;
        timeout        <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end

      if (!active || activity) wdog <= '0;
      else                     wdog <= wdog + 32'd1;
      if (wd_fire) timeout <= 1'b1;

      if ((state == S_WR_DATA) && datain_rdy) begin
        write_data <= wr_pat;
        wr_beat    <= ~wr_beat;
        if (wr_beat) cmd_idx <= (cmd_idx == LAST_CMD) ? '0 : cmd_idx + 16'd1;
      end

      if ((state == S_RD_CMD) && cmd_acc) cmd_idx <= cmd_idx + 16'd1;

      // err_count==0 doubles as the "no mismatch seen yet" flag.
      if (rx_take) begin
        rx_cnt <= rx_cnt + 17'd1;
        if (read_data != rd_pat) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (err_count == 16'd0)
            first_err_addr <= BASE + ADDR_W'(rx_cnt >> 1) * STEP;
        end
      end

      if (state == S_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == 16'd0) && !timeout;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_mem_tester.sv
// Randomised controller model plus behavioural scoreboard for ddr3_mem_tester.
module tb_ddr3_mem_tester;

  localparam int          ADDR_W = 26;
  localparam int          DATA_W = 64;
  localparam int          N      = 4;
  localparam int          TMO    = 64;
  localparam logic [31:0] SEED   = 32'h5A5A_1234;

  logic                clk = 1'b0, rstn = 1'b0, start = 1'b0, init_done = 1'b0;
  logic                cmd_rdy = 1'b0, datain_rdy = 1'b0, read_data_valid = 1'b0;
  logic [DATA_W-1:0]   read_data = '0;
  logic [3:0]          cmd;
  logic                cmd_valid, ofly_burst_len, busy, done, pass, timeout;
  logic [ADDR_W-1:0]   addr, first_err_addr;
  logic [4:0]          cmd_burst_cnt;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W/8-1:0] data_mask;
  logic [15:0]         err_count;

  ddr3_mem_tester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CMDS(N), .BASE_ADDR(0),
    .SEED(SEED), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .init_done(init_done),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy), .addr(addr),
    .cmd_burst_cnt(cmd_burst_cnt), .ofly_burst_len(ofly_burst_len),
    .write_data(write_data), .data_mask(data_mask), .datain_rdy(datain_rdy),
    .read_data(read_data), .read_data_valid(read_data_valid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int unsigned b);
    logic [31:0] w;
    w = b ^ SEED;
    return {~w, w};
  endfunction

  // Controller / memory model knobs and state
  int  rdy_mode = 0;      // 0 always ready, 1 random, 2 stall 10 cycles per command
  bit  no_read = 1'b0;
  int  corrupt_beat = -1;
  int  lat_min = 6, lat_max = 6;
  logic [63:0] mem [int];
  int  wr_owed, wr_k, stall_cnt, cyc, rd_sent, last_due;
  logic [ADDR_W-1:0] wr_addr, acc_addr;
  logic [3:0] acc_cmd;
  bit  cap_pend, acc_pend;
  int  rq_due[$];
  logic [63:0] rq_data[$];

  initial begin
    wr_owed = 0; wr_k = 0; stall_cnt = 0; cyc = 0; rd_sent = 0; last_due = 0;
    cap_pend = 0; acc_pend = 0; wr_addr = '0; acc_addr = '0; acc_cmd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        wr_owed = 0; cap_pend = 0; acc_pend = 0; stall_cnt = 0; last_due = 0;
        rq_due.delete(); rq_data.delete();
        cmd_rdy = 0; datain_rdy = 0; read_data_valid = 0;
        continue;
      end
      if (cap_pend) begin
        mem[int'(wr_addr) * 2 + wr_k] = write_data;
        wr_k++;
      end
      cap_pend = 0;
      if (acc_pend) begin
        if (acc_cmd == 4'b0010) begin
          wr_owed = 2; wr_k = 0; wr_addr = acc_addr;
        end else if (acc_cmd == 4'b0001 && !no_read) begin
          for (int k = 0; k < 2; k++) begin
            logic [63:0] d;
            int due;
            d = mem.exists(int'(acc_addr) * 2 + k) ? mem[int'(acc_addr) * 2 + k] : 64'd0;
            if (rd_sent == corrupt_beat) d[0] = ~d[0];
            rd_sent++;
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rq_due.push_back(due);
            rq_data.push_back(d);
          end
        end
      end
      acc_pend = 0;
      datain_rdy = 0;
      if (wr_owed > 0 && (rdy_mode != 1 || $urandom_range(0, 3) != 0)) begin
        datain_rdy = 1; wr_owed--; cap_pend = 1;
      end
      read_data_valid = 0;
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        read_data_valid = 1;
        read_data = rq_data.pop_front();
        void'(rq_due.pop_front());
      end
      case (rdy_mode)
        0: cmd_rdy = 1;
        1: cmd_rdy = ($urandom_range(0, 1) == 1);
        default: begin
          if (cmd_valid && stall_cnt < 10) begin cmd_rdy = 0; stall_cnt++; end
          else cmd_rdy = cmd_valid;
        end
      endcase
      if (cmd_valid && cmd_rdy) begin
        acc_pend = 1; acc_cmd = cmd; acc_addr = addr; stall_cnt = 0;
      end
    end
  end

  // Behavioural scoreboard: samples the values the DUT will see at the next rising edge.
  int exp_acc, exp_wb, exp_rx, exp_err, exp_first, idle_run;
  bit prev_pend, prev_drdy, prev_timeout;
  logic [3:0] prev_cmd;
  logic [ADDR_W-1:0] prev_addr;

  initial begin
    exp_acc = 0; exp_wb = 0; exp_rx = 0; exp_err = 0; exp_first = 0; idle_run = 0;
    prev_pend = 0; prev_drdy = 0; prev_timeout = 0; prev_cmd = '0; prev_addr = '0;
    forever begin
      @(negedge clk); #1;
      if (!rstn) begin
        exp_acc = 0; exp_wb = 0; exp_rx = 0; exp_err = 0; exp_first = 0; idle_run = 0;
        prev_pend = 0; prev_drdy = 0; prev_timeout = 0;
        continue;
      end
      if (start && !busy) begin
        exp_acc = 0; exp_wb = 0; exp_rx = 0; exp_err = 0; exp_first = 0; idle_run = 0;
      end
      if (busy) check("err_count_track", 64'(err_count), 64'(exp_err));
      if (timeout && !prev_timeout) check("timeout_idle_cycles", 64'(idle_run), 64'(TMO));
      if (prev_drdy) begin
        check("write_beat", write_data, pat(exp_wb));
        exp_wb++;
      end
      if (prev_pend && !timeout)
        check("cmd_hold", 64'({cmd_valid, cmd, addr}), 64'({1'b1, prev_cmd, prev_addr}));
      if (cmd_valid && cmd_rdy) begin
        logic [3:0] ec;
        ec = (exp_acc < N) ? 4'b0010 : (exp_acc < 2 * N) ? 4'b0001 : 4'hF;
        check("cmd_accept", 64'({cmd, addr}), 64'({ec, ADDR_W'(8 * (exp_acc % N))}));
        exp_acc++;
      end
      if (read_data_valid && exp_rx < 2 * N) begin
        if (read_data !== pat(exp_rx)) begin
          if (exp_err < 65535) exp_err++;
          if (exp_err == 1) exp_first = 8 * (exp_rx / 2);
        end
        exp_rx++;
      end
      if (busy && !((cmd_valid && cmd_rdy) || datain_rdy || read_data_valid)) idle_run++;
      else idle_run = 0;
      prev_pend    = cmd_valid && !cmd_rdy;
      prev_cmd     = cmd;
      prev_addr    = addr;
      prev_drdy    = datain_rdy;
      prev_timeout = timeout;
    end
  end

  task automatic run_test(input string name, input int mode, input bit nr, input int corrupt,
                          input bit exp_tmo, input bit poke_start);
    int n;
    rdy_mode = mode; no_read = nr; corrupt_beat = corrupt; rd_sent = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      start = (poke_start && n == 20);
      n++;
    end
    start = 0;
    #1;
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_idle"}, 64'({busy, cmd_valid}), 64'd0);
    check({name, "_timeout"}, 64'(timeout), 64'(exp_tmo));
    check({name, "_pass"}, 64'(pass), 64'(exp_err == 0 && !exp_tmo));
    check({name, "_err_count"}, 64'(err_count), 64'(exp_err));
    check({name, "_first_err"}, 64'(first_err_addr), 64'(exp_first));
    check({name, "_consts"}, 64'({cmd_burst_cnt, ofly_burst_len, data_mask}), 64'({5'd1, 1'b0, 8'd0}));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, c;
    repeat (3) @(negedge clk);
    #1;
    check("rst_flags", 64'({busy, done, pass, timeout}), 64'd0);
    check("rst_err", 64'({err_count, first_err_addr}), 64'd0);
    check("rst_cmd", 64'({cmd_valid, cmd, addr}), 64'd0);
    check("rst_wdata", write_data, 64'd0);
    @(negedge clk); #2 rstn = 1;

    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    check("no_init_busy", 64'({busy, cmd_valid, done}), 64'd0);
    init_done = 1;

    run_test("ideal", 0, 0, -1, 0, 0);
    check("ideal_first_beat", mem[0], 64'hA5A5EDCB_5A5A1234);
    check("ideal_last_addr_written", 64'(mem.exists(24 * 2 + 1)), 64'd1);
    check("ideal_pass_lit", 64'({pass, err_count}), {47'd0, 1'b1, 16'd0});

    run_test("corrupt5", 0, 0, 5, 0, 0);
    check("corrupt5_lit", 64'({pass, err_count, first_err_addr}), 64'({1'b0, 16'd1, 26'd16}));

    run_test("stall", 2, 0, -1, 0, 0);
    check("stall_pass_lit", 64'(pass), 64'd1);

    run_test("noread", 0, 1, -1, 1, 0);
    check("noread_lit", 64'({done, pass, timeout, cmd_valid}), 64'b1010);

    rdy_mode = 0; no_read = 0; corrupt_beat = -1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    n = 0;
    while (!cap_pend && n < 200) begin @(negedge clk); #2; n++; end
    check("rst_reached_wr_data", 64'(cap_pend), 64'd1);
    rstn = 0;
    #1;
    check("midrst_flags", 64'({busy, done, pass, timeout}), 64'd0);
    check("midrst_cmd", 64'({cmd_valid, cmd, addr}), 64'd0);
    check("midrst_data", 64'({err_count, first_err_addr}), 64'd0);
    check("midrst_wdata", write_data, 64'd0);
    repeat (2) @(negedge clk);
    #2 rstn = 1;
    repeat (2) @(negedge clk);
    run_test("after_rst", 0, 0, -1, 0, 0);

    for (int t = 0; t < 6; t++) begin
      lat_min = 1;
      lat_max = int'($urandom_range(1, 12));
      c = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
      run_test("rand", 1, 0, c, 0, (t % 2) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
